// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared state encoding and round constants for the ASCON-128 controller
package ascon_pack;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      WAIT_AD = 3'd2,
      AD      = 3'd3,
      WAIT_PT = 3'd4,
      PT      = 3'd5,
      FINAL   = 3'd6,
      END     = 3'd7
   } ascon_state_t;

   localparam logic [3:0] ROUND_A_START = 4'd0;
   localparam logic [3:0] ROUND_B_START = 4'd6;
   localparam logic [3:0] ROUND_LAST    = 4'd11;

   function automatic logic is_perm_state(input ascon_state_t s);
      return (s == INIT) || (s == AD) || (s == PT) || (s == FINAL);
   endfunction

endpackage

// File: rtl/compteur_blocs.sv
// rtl/compteur_blocs.sv - 2-bit plaintext block index, cleared or incremented on enable
module compteur_blocs (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       en_i,
   input  logic       init_bloc_i,
   output logic [1:0] bloc_o
);

   logic [1:0] r_bloc;

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i)
         r_bloc <= 2'd0;
      else if (en_i)
         r_bloc <= init_bloc_i ? 2'd0 : r_bloc + 2'd1;
   end

   assign bloc_o = r_bloc;

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// rtl/ascon_ctrl_fsm.sv - Moore sequencer for the ASCON-128 permutation datapath (1 AD block, NB_PT_BLOCKS PT blocks)
module ascon_ctrl_fsm
   import ascon_pack::*;
#(
   parameter int NB_PT_BLOCKS = 3
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       data_valid_i,
   output logic       data_ready_o,
   output logic [3:0] round_o,
   output logic       perm_en_o,
   output logic       mux_init_o,
   output logic       xor_data_begin_o,
   output logic       xor_key_begin_o,
   output logic       xor_key_end_o,
   output logic       xor_lsb_end_o,
   output logic       cipher_valid_o,
   output logic       tag_valid_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [1:0] bloc_o
);

   localparam logic [1:0] LAST_BLOC = 2'(NB_PT_BLOCKS - 1);

   ascon_state_t r_state;
   ascon_state_t w_next;
   logic [3:0]   r_round;
   logic         w_ready;
   logic         w_hs;
   logic         w_perm;
   logic         w_last;
   logic         w_idle_or_end;
   logic         w_init_bloc;
   logic         w_bloc_inc;
   logic [1:0]   w_bloc;

   assign w_ready       = (r_state == WAIT_AD) || (r_state == WAIT_PT);
   assign w_hs          = w_ready && data_valid_i;
   assign w_perm        = is_perm_state(r_state);
   assign w_last        = (r_round == ROUND_LAST);
   assign w_idle_or_end = (r_state == IDLE) || (r_state == END);
   assign w_init_bloc   = w_idle_or_end && start_i;
   assign w_bloc_inc    = (r_state == PT) && w_last;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, END: if (start_i) w_next = INIT;
         INIT:      if (w_last)  w_next = WAIT_AD;
         WAIT_AD:   if (w_hs)    w_next = AD;
         AD:        if (w_last)  w_next = WAIT_PT;
         WAIT_PT:   if (w_hs)    w_next = (w_bloc < LAST_BLOC) ? PT : FINAL;
         PT:        if (w_last)  w_next = WAIT_PT;
         FINAL:     if (w_last)  w_next = END;
         default:                w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Load on entry to a permutation state; leaving one holds the counter at ROUND_LAST.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         r_round <= 4'd0;
      end else if (w_next != r_state) begin
         case (w_next)
            INIT, FINAL: r_round <= ROUND_A_START;
            AD, PT:      r_round <= ROUND_B_START;
            default:     r_round <= r_round;
         endcase
      end else if (w_perm && !w_last) begin
         r_round <= r_round + 4'd1;
      end
   end

   compteur_blocs u_compteur_blocs (
      .clock_i     (clock_i),
      .resetb_i    (resetb_i),
      .en_i        (w_bloc_inc | w_init_bloc),
      .init_bloc_i (w_init_bloc),
      .bloc_o      (w_bloc)
   );

   assign data_ready_o     = w_ready;
   assign round_o          = r_round;
   assign perm_en_o        = w_perm;
   assign mux_init_o       = (r_state == INIT) && (r_round == ROUND_A_START);
   assign xor_data_begin_o = (((r_state == AD) || (r_state == PT)) && (r_round == ROUND_B_START))
                           || ((r_state == FINAL) && (r_round == ROUND_A_START));
   assign xor_key_begin_o  = (r_state == FINAL) && (r_round == ROUND_A_START);
   assign xor_key_end_o    = ((r_state == INIT) || (r_state == FINAL)) && w_last;
   assign xor_lsb_end_o    = (r_state == AD) && w_last;
   assign cipher_valid_o   = ((r_state == PT) && (r_round == ROUND_B_START))
                           || ((r_state == FINAL) && (r_round == ROUND_A_START));
   assign tag_valid_o      = (r_state == END);
   assign done_o           = (r_state == END);
   assign busy_o           = !w_idle_or_end;
   assign bloc_o           = w_bloc;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// tb/tb_ascon_ctrl_fsm.sv - directed vector bench for ascon_ctrl_fsm (NB_PT_BLOCKS=3 and 1)
module tb_ascon_ctrl_fsm;

   localparam logic [6:0] F_MUX = 7'b1000000;
   localparam logic [6:0] F_XDB = 7'b0100000;
   localparam logic [6:0] F_XKB = 7'b0010000;
   localparam logic [6:0] F_XKE = 7'b0001000;
   localparam logic [6:0] F_XLE = 7'b0000100;
   localparam logic [6:0] F_CV  = 7'b0000010;
   localparam logic [6:0] F_TV  = 7'b0000001;

   typedef struct {
      logic       start;
      logic       dv;
      int         reps;
      logic [3:0] r0;
      logic       perm;
      logic       ready;
      logic       busy;
      logic       done;
      logic [1:0] bloc;
      logic [6:0] f_first;
      logic [6:0] f_last;
      logic [6:0] f_all;
   } vec_t;

   logic clock_i = 1'b0;
   logic resetb_i = 1'b0;
   logic start0 = 1'b0, dv0 = 1'b0, start1 = 1'b0, dv1 = 1'b0;

   logic       rdy0, perm0, mux0, xdb0, xkb0, xke0, xle0, cv0, tv0, busy0, done0;
   logic [3:0] round0;
   logic [1:0] bloc0;
   logic       rdy1, perm1, mux1, xdb1, xkb1, xke1, xle1, cv1, tv1, busy1, done1;
   logic [3:0] round1;
   logic [1:0] bloc1;

   int n_vec = 0;
   int n_miss = 0;
   int hs_count = 0;
   vec_t tbl[13];

   always #5 clock_i = ~clock_i;

   ascon_ctrl_fsm #(.NB_PT_BLOCKS(3)) dut0 (
      .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start0), .data_valid_i(dv0),
      .data_ready_o(rdy0), .round_o(round0), .perm_en_o(perm0), .mux_init_o(mux0),
      .xor_data_begin_o(xdb0), .xor_key_begin_o(xkb0), .xor_key_end_o(xke0),
      .xor_lsb_end_o(xle0), .cipher_valid_o(cv0), .tag_valid_o(tv0), .busy_o(busy0),
      .done_o(done0), .bloc_o(bloc0)
   );

   ascon_ctrl_fsm #(.NB_PT_BLOCKS(1)) dut1 (
      .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start1), .data_valid_i(dv1),
      .data_ready_o(rdy1), .round_o(round1), .perm_en_o(perm1), .mux_init_o(mux1),
      .xor_data_begin_o(xdb1), .xor_key_begin_o(xkb1), .xor_key_end_o(xke1),
      .xor_lsb_end_o(xle1), .cipher_valid_o(cv1), .tag_valid_o(tv1), .busy_o(busy1),
      .done_o(done1), .bloc_o(bloc1)
   );

   function automatic logic [16:0] mk(input logic ready, input logic busy, input logic done,
                                      input logic perm, input logic [3:0] round,
                                      input logic [1:0] bloc, input logic [6:0] flags);
      return {ready, busy, done, perm, round, bloc, flags};
   endfunction

   function automatic logic [16:0] obs0();
      return {rdy0, busy0, done0, perm0, round0, bloc0, mux0, xdb0, xkb0, xke0, xle0, cv0, tv0};
   endfunction

   function automatic logic [16:0] obs1();
      return {rdy1, busy1, done1, perm1, round1, bloc1, mux1, xdb1, xkb1, xke1, xle1, cv1, tv1};
   endfunction

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got rdy/busy/done/perm/round/bloc/flags=%b, expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   initial begin
      logic [3:0] er;
      logic [6:0] ef;

      //          start dv reps r0 perm rdy busy done bloc first           last   all
      tbl[0]  = '{1'b1, 1'b1, 1,  4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, F_MUX, F_MUX, 7'd0};
      tbl[1]  = '{1'b0, 1'b1, 11, 4'd1,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'd0,  F_XKE, 7'd0};
      tbl[2]  = '{1'b0, 1'b1, 1,  4'd11, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 7'd0,  7'd0,  7'd0};
      tbl[3]  = '{1'b0, 1'b1, 6,  4'd6,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, F_XDB, F_XLE, 7'd0};
      tbl[4]  = '{1'b0, 1'b1, 1,  4'd11, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 7'd0,  7'd0,  7'd0};
      tbl[5]  = '{1'b0, 1'b1, 6,  4'd6,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, F_XDB | F_CV, 7'd0, 7'd0};
      tbl[6]  = '{1'b0, 1'b1, 1,  4'd11, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 7'd0,  7'd0,  7'd0};
      tbl[7]  = '{1'b0, 1'b1, 6,  4'd6,  1'b1, 1'b0, 1'b1, 1'b0, 2'd1, F_XDB | F_CV, 7'd0, 7'd0};
      tbl[8]  = '{1'b0, 1'b1, 1,  4'd11, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 7'd0,  7'd0,  7'd0};
      tbl[9]  = '{1'b0, 1'b1, 12, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 2'd2, F_XDB | F_XKB | F_CV, F_XKE, 7'd0};
      tbl[10] = '{1'b0, 1'b1, 3,  4'd11, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 7'd0,  7'd0,  F_TV};
      tbl[11] = '{1'b1, 1'b0, 1,  4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, F_MUX, F_MUX, 7'd0};
      tbl[12] = '{1'b0, 1'b0, 5,  4'd1,  1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 7'd0,  7'd0,  7'd0};

      step();
      step();
      check("reset_state0", obs0(), 17'd0);
      check("reset_state1", obs1(), 17'd0);
      resetb_i = 1'b1;
      step();
      check("idle_after_release", obs0(), 17'd0);

      for (int i = 0; i < 13; i++) begin
         start0 = tbl[i].start;
         dv0    = tbl[i].dv;
         for (int k = 0; k < tbl[i].reps; k++) begin
            if (rdy0 && dv0) hs_count++;
            step();
            er = tbl[i].perm ? tbl[i].r0 + 4'(k) : tbl[i].r0;
            ef = tbl[i].f_all;
            if (k == 0) ef = ef | tbl[i].f_first;
            else if (k == tbl[i].reps - 1) ef = ef | tbl[i].f_last;
            check($sformatf("tbl%0d_cyc%0d", i, k), obs0(),
                  mk(tbl[i].ready, tbl[i].busy, tbl[i].done, tbl[i].perm, er, tbl[i].bloc, ef));
         end
         if (i == 10) begin
            n_vec++;
            if (hs_count != 4) begin
               n_miss++;
               $display("FAIL handshake_count: got %0d, expected 4", hs_count);
            end
         end
      end

      // Asynchronous reset while INIT sits at round 5, away from any clock edge.
      start0 = 1'b0;
      #2;
      resetb_i = 1'b0;
      #1;
      check("reset_mid_init", obs0(), 17'd0);
      step();
      resetb_i = 1'b1;
      step();
      check("idle_after_mid_reset", obs0(), 17'd0);
      start0 = 1'b1;
      step();
      check("restart_init_r0", obs0(), mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd0, F_MUX));
      start0 = 1'b0;
      step();
      check("restart_init_r1", obs0(), mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 2'd0, 7'd0));

      // NB_PT_BLOCKS=1: WAIT_PT handshake goes straight to FINAL.
      start1 = 1'b1;
      step();
      check("nb1_init_r0", obs1(), mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd0, F_MUX));
      start1 = 1'b0;
      repeat (11) step();
      check("nb1_init_r11", obs1(), mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd11, 2'd0, F_XKE));
      step();
      check("nb1_wait_ad", obs1(), mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd11, 2'd0, 7'd0));
      dv1 = 1'b1;
      step();
      check("nb1_ad_r6", obs1(), mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 2'd0, F_XDB));
      dv1 = 1'b0;
      repeat (5) step();
      check("nb1_ad_r11", obs1(), mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd11, 2'd0, F_XLE));
      step();
      check("nb1_wait_pt", obs1(), mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd11, 2'd0, 7'd0));
      dv1 = 1'b1;
      step();
      check("nb1_final_r0", obs1(), mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd0, F_XDB | F_XKB | F_CV));
      dv1 = 1'b0;
      repeat (11) step();
      check("nb1_final_r11", obs1(), mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd11, 2'd0, F_XKE));
      step();
      check("nb1_end", obs1(), mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd11, 2'd0, F_TV));
      step();
      check("nb1_end_held", obs1(), mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd11, 2'd0, F_TV));
      start1 = 1'b1;
      step();
      check("nb1_restart_from_end", obs1(), mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 2'd0, F_MUX));
      start1 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
